// File: rtl/irq_pkg.sv
// irq_pkg: shared definitions for the machine-mode interrupt/timer block.
//   - irq_state_e   : request FSM states (IDLE, REQ, SERVICE)
//   - CAUSE_M_*     : mcause values driven on irq_cause
//   - REG_*         : register index decoded from bus_addr[3:2]
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_e;

    localparam logic [31:0] CAUSE_M_TIMER = 32'h8000_0007;
    localparam logic [31:0] CAUSE_M_EXT   = 32'h8000_000B;

    localparam logic [1:0] REG_MTIME_LO    = 2'd0;
    localparam logic [1:0] REG_MTIME_HI    = 2'd1;
    localparam logic [1:0] REG_MTIMECMP_LO = 2'd2;
    localparam logic [1:0] REG_MTIMECMP_HI = 2'd3;

endpackage

// File: rtl/irq_sync2.sv
// irq_sync2: two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk, rst : clock, synchronous active-high reset (both flops clear to 0)
//   i_d      : asynchronous input
//   o_q      : synchronised output, two clk edges after i_d changes
module irq_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/irq_timer_ctrl.sv
// irq_timer_ctrl: machine-mode interrupt source and trap initiator.
// Holds the 64-bit mtime/mtimecmp timer (memory mapped), synchronises the
// external interrupt line, arbitrates timer/external against the CSR enables
// and runs the trap request handshake (IDLE -> REQ -> SERVICE -> IDLE).
//
// Optional build macro EXT_IRQ_EDGE_EN: when defined, meip is a sticky latch
// set by a rising edge of the synchronised ext_irq and cleared when an
// external-cause request is acknowledged. When undefined, meip is the level.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   bus_sel/bus_wr : access strobe / write select
//   bus_addr       : byte address, [3:2] selects mtime/mtimecmp half
//   bus_wdata      : write data
//   bus_rdata      : combinational read data (0 unless a read is selected)
//   ext_irq        : asynchronous external interrupt, level high
//   mstatus_mie, mie_mtie, mie_meie : enables from the CSR file
//   epc_taken      : core accepted the trap redirect
//   is_mret        : core executing mret
//   trap, irq_cause: request and its mcause value
//   mtip, meip     : pending bits for mip
module irq_timer_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_sel,
    input  logic        bus_wr,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    input  logic        ext_irq,
    input  logic        mstatus_mie,
    input  logic        mie_mtie,
    input  logic        mie_meie,
    input  logic        epc_taken,
    input  logic        is_mret,
    output logic        trap,
    output logic [31:0] irq_cause,
    output logic        mtip,
    output logic        meip
);

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic [15:0] r_presc;
    logic        r_mtip;
    irq_state_e  r_state;
    irq_state_e  w_state_next;
    logic [31:0] r_cause;
    logic [31:0] w_cause_next;
    logic        w_hit;
    logic        w_wr;
    logic        w_tick;
    logic [1:0]  w_reg;
    logic        w_ext_sync;
    logic        w_elig;
    logic        w_unused_addr;

    // Byte-lane bits carry no meaning for word registers.
    assign w_unused_addr = ^bus_addr[1:0];

    assign w_hit  = bus_sel && (bus_addr[31:4] == BASE_ADDR[31:4]);
    assign w_wr   = w_hit && bus_wr;
    assign w_reg  = bus_addr[3:2];
    assign w_tick = (r_presc == PRESC_LAST);

    always_comb begin
        bus_rdata = 32'h0;
        if (w_hit && !bus_wr) begin
            case (w_reg)
                REG_MTIME_LO:    bus_rdata = r_mtime[31:0];
                REG_MTIME_HI:    bus_rdata = r_mtime[63:32];
                REG_MTIMECMP_LO: bus_rdata = r_mtimecmp[31:0];
                default:         bus_rdata = r_mtimecmp[63:32];
            endcase
        end
    end

    // A software write to either mtime half wins over that cycle's tick;
    // the other half holds and no carry is propagated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= 64'h0;
            r_mtimecmp <= '1;
            r_presc    <= 16'h0;
            r_mtip     <= 1'b0;
        end else begin
            r_presc <= w_tick ? 16'h0 : r_presc + 16'h1;
            r_mtip  <= (r_mtime >= r_mtimecmp);
            if (w_wr && w_reg == REG_MTIME_LO) begin
                r_mtime[31:0] <= bus_wdata;
            end else if (w_wr && w_reg == REG_MTIME_HI) begin
                r_mtime[63:32] <= bus_wdata;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'h1;
            end
            if (w_wr && w_reg == REG_MTIMECMP_LO) begin
                r_mtimecmp[31:0] <= bus_wdata;
            end
            if (w_wr && w_reg == REG_MTIMECMP_HI) begin
                r_mtimecmp[63:32] <= bus_wdata;
            end
        end
    end

    assign mtip = r_mtip;

    irq_sync2 u_ext_sync (
        .clk (clk),
        .rst (rst),
        .i_d (ext_irq),
        .o_q (w_ext_sync)
    );

`ifdef EXT_IRQ_EDGE_EN
    logic r_sync_prev;
    logic r_meip;
    logic w_ack_ext;

    assign w_ack_ext = (r_state == REQ) && epc_taken && (r_cause == CAUSE_M_EXT);

    // A fresh edge in the acknowledge cycle wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_prev <= 1'b0;
            r_meip      <= 1'b0;
        end else begin
            r_sync_prev <= w_ext_sync;
            r_meip      <= (w_ext_sync && !r_sync_prev) || (r_meip && !w_ack_ext);
        end
    end

    assign meip = r_meip;
`else
    assign meip = w_ext_sync;
`endif

    assign w_elig = mstatus_mie && ((meip && mie_meie) || (mtip && mie_mtie));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cause <= 32'h0;
        end else begin
            r_state <= w_state_next;
            r_cause <= w_cause_next;
        end
    end

    // epc_taken is checked before eligibility in REQ so an ack that
    // coincides with mret or a dropping source still enters SERVICE.
    always_comb begin
        w_state_next = r_state;
        w_cause_next = r_cause;
        trap         = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_elig) begin
                    w_state_next = REQ;
                    w_cause_next = (meip && mie_meie) ? CAUSE_M_EXT : CAUSE_M_TIMER;
                end
            end
            REQ: begin
                trap = 1'b1;
                if (epc_taken) begin
                    w_state_next = SERVICE;
                end else if (!w_elig) begin
                    w_state_next = IDLE;
                end
            end
            SERVICE: begin
                if (is_mret) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign irq_cause = r_cause;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Self-checking bench for irq_timer_ctrl: directed scenarios followed by a
// randomized run, all compared cycle by cycle with a behavioural model.
module tb_irq_timer_ctrl;

    localparam int unsigned TB_PRESCALE = 1;
    localparam logic [31:0] TB_BASE     = 32'h0200_0000;
    localparam logic [31:0] EXP_TIMER   = 32'h8000_0007;
    localparam logic [31:0] EXP_EXT     = 32'h8000_000B;
`ifdef EXT_IRQ_EDGE_EN
    localparam int EXP_MEIP_LAT = 3;
`else
    localparam int EXP_MEIP_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_sel;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        ext_irq;
    logic        mstatus_mie;
    logic        mie_mtie;
    logic        mie_meie;
    logic        epc_taken;
    logic        is_mret;
    logic        trap;
    logic [31:0] irq_cause;
    logic        mtip;
    logic        meip;

    always #5 clk = ~clk;

    irq_timer_ctrl #(.PRESCALE(TB_PRESCALE), .BASE_ADDR(TB_BASE)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_sel     (bus_sel),
        .bus_wr      (bus_wr),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .ext_irq     (ext_irq),
        .mstatus_mie (mstatus_mie),
        .mie_mtie    (mie_mtie),
        .mie_meie    (mie_meie),
        .epc_taken   (epc_taken),
        .is_mret     (is_mret),
        .trap        (trap),
        .irq_cause   (irq_cause),
        .mtip        (mtip),
        .meip        (meip)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: timer as a plain 64-bit count, the external line as
    // a history of sampled values, the handshake as two flags.
    bit [63:0] m_time;
    bit [63:0] m_cmp;
    int        m_presc;
    bit        m_mtip;
    bit        m_meip;
    bit        m_requesting;
    bit        m_in_handler;
    bit [31:0] m_cause;
    bit        ext_hist[$];
    logic [31:0] last_rd;

    function automatic logic [31:0] model_rdata();
        if (!bus_sel || bus_wr) return 32'h0;
        case (bus_addr[3:2])
            2'd0:    return m_time[31:0];
            2'd1:    return m_time[63:32];
            2'd2:    return m_cmp[31:0];
            default: return m_cmp[63:32];
        endcase
    endfunction

    task automatic model_step();
        bit elig;
        bit ext_pend;
        bit ack_ext;
        bit new_mtip;
        bit wr;
        int idx;
        if (rst) begin
            m_time = 64'h0;
            m_cmp = {64{1'b1}};
            m_presc = 0;
            m_mtip = 0;
            m_meip = 0;
            m_requesting = 0;
            m_in_handler = 0;
            m_cause = 32'h0;
            ext_hist = {1'b0, 1'b0, 1'b0, 1'b0};
            return;
        end
        ext_pend = m_meip && mie_meie;
        elig = mstatus_mie && (ext_pend || (m_mtip && mie_mtie));
        ack_ext = m_requesting && epc_taken && (m_cause == EXP_EXT);
        new_mtip = (m_time >= m_cmp);
        wr = bus_sel && bus_wr;
        idx = int'(bus_addr[3:2]);
        if (wr && idx == 0) m_time = {m_time[63:32], bus_wdata};
        else if (wr && idx == 1) m_time = {bus_wdata, m_time[31:0]};
        else if (m_presc == TB_PRESCALE - 1) m_time = m_time + 64'd1;
        if (wr && idx == 2) m_cmp = {m_cmp[63:32], bus_wdata};
        if (wr && idx == 3) m_cmp = {bus_wdata, m_cmp[31:0]};
        m_presc = (m_presc == TB_PRESCALE - 1) ? 0 : m_presc + 1;
        if (m_requesting) begin
            if (epc_taken) begin
                m_requesting = 0;
                m_in_handler = 1;
            end else if (!elig) begin
                m_requesting = 0;
            end
        end else if (m_in_handler) begin
            if (is_mret) m_in_handler = 0;
        end else if (elig) begin
            m_requesting = 1;
            m_cause = ext_pend ? EXP_EXT : EXP_TIMER;
        end
        ext_hist.push_back(ext_irq);
        if (ext_hist.size() > 8) void'(ext_hist.pop_front());
`ifdef EXT_IRQ_EDGE_EN
        m_meip = (ext_hist[$-2] && !ext_hist[$-3]) || (m_meip && !ack_ext);
`else
        m_meip = ext_hist[$-1];
`endif
        m_mtip = new_mtip;
    endtask

    // Inputs are set around the falling edge; the DUT clocks at the rising
    // edge in between and outputs are compared at the next falling edge.
    task automatic do_cycle();
        #1;
        last_rd = bus_rdata;
        check("rdata", bus_rdata, model_rdata());
        model_step();
        @(negedge clk);
        check("trap", trap, m_requesting);
        check("irq_cause", irq_cause, m_cause);
        check("mtip", mtip, m_mtip);
        check("meip", meip, m_meip);
    endtask

    task automatic bus_write(input int idx, input logic [31:0] data);
        bus_sel = 1'b1;
        bus_wr = 1'b1;
        bus_addr = TB_BASE | (32'(idx) << 2);
        bus_wdata = data;
        do_cycle();
        bus_sel = 1'b0;
        bus_wr = 1'b0;
    endtask

    task automatic bus_read(input int idx);
        bus_sel = 1'b1;
        bus_wr = 1'b0;
        bus_addr = TB_BASE | (32'(idx) << 2);
        do_cycle();
        bus_sel = 1'b0;
    endtask

    task automatic wait_trap(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles && trap !== 1'b1; i++) do_cycle();
        check(tag, trap, 1'b1);
    endtask

    task automatic pulse_ack();
        epc_taken = 1'b1;
        do_cycle();
        epc_taken = 1'b0;
    endtask

    task automatic pulse_mret();
        is_mret = 1'b1;
        do_cycle();
        is_mret = 1'b0;
    endtask

    task automatic randomize_inputs();
        int idx;
        rst = ($urandom_range(0, 299) == 0);
        bus_sel = ($urandom_range(0, 3) == 0);
        bus_wr = $urandom_range(0, 1);
        idx = $urandom_range(0, 3);
        bus_addr = TB_BASE | (32'(idx) << 2);
        if (idx[0] == 1'b1) begin
            bus_wdata = ($urandom_range(0, 7) == 0) ? $urandom : 32'h0;
        end else begin
            case ($urandom_range(0, 7))
                0:       bus_wdata = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                1:       bus_wdata = $urandom;
                default: bus_wdata = $urandom_range(0, 64);
            endcase
        end
        if ($urandom_range(0, 15) == 0) ext_irq = ~ext_irq;
        if ($urandom_range(0, 19) == 0) mstatus_mie = ~mstatus_mie;
        if ($urandom_range(0, 19) == 0) mie_mtie = ~mie_mtie;
        if ($urandom_range(0, 19) == 0) mie_meie = ~mie_meie;
        epc_taken = ($urandom_range(0, 3) == 0);
        is_mret = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        bus_sel = 1'b0;
        bus_wr = 1'b0;
        bus_addr = TB_BASE;
        bus_wdata = 32'h0;
        ext_irq = 1'b0;
        mstatus_mie = 1'b0;
        mie_mtie = 1'b0;
        mie_meie = 1'b0;
        epc_taken = 1'b0;
        is_mret = 1'b0;

        do_cycle();
        do_cycle();
        check("rst_trap", trap, 1'b0);
        check("rst_cause", irq_cause, 32'h0);
        check("rst_mtip", mtip, 1'b0);
        check("rst_meip", meip, 1'b0);
        rst = 1'b0;
        bus_read(3);
        check("rst_cmp_hi", last_rd, 32'hFFFF_FFFF);

        // Timer request path.
        bus_write(2, 32'd10);
        bus_write(3, 32'd0);
        mstatus_mie = 1'b1;
        mie_mtie = 1'b1;
        wait_trap("t1_trap", 40);
        check("t1_cause", irq_cause, EXP_TIMER);

        // Hold, acknowledge, no re-request in service, re-request after mret.
        do_cycle();
        do_cycle();
        do_cycle();
        check("t2_hold", trap, 1'b1);
        pulse_ack();
        check("t2_ack_drop", trap, 1'b0);
        for (int i = 0; i < 4; i++) do_cycle();
        check("t2_service_quiet", trap, 1'b0);
        pulse_mret();
        check("t2_idle_cycle", trap, 1'b0);
        do_cycle();
        check("t2_rereq", trap, 1'b1);
        pulse_ack();

        // External and timer both pending: external wins.
        mie_meie = 1'b1;
        ext_irq = 1'b1;
        lat = 0;
        for (int i = 1; i <= 6 && lat == 0; i++) begin
            do_cycle();
            if (meip === 1'b1) lat = i;
        end
        check("t3_meip_lat", 64'(lat), 64'(EXP_MEIP_LAT));
        pulse_mret();
        wait_trap("t3_trap", 4);
        check("t3_cause", irq_cause, EXP_EXT);
        pulse_ack();
        ext_irq = 1'b0;
        pulse_mret();
        mie_meie = 1'b0;
        mie_mtie = 1'b0;

        // mtime carry into the upper half; write beats the increment.
        bus_write(0, 32'hFFFF_FFFF);
        bus_write(1, 32'h0);
        do_cycle();
        bus_read(1);
        check("t4_carry_hi", last_rd, 32'h1);
        bus_write(0, 32'd5);
        bus_read(0);
        check("t4_write_wins", last_rd, 32'd5);

        // Enable dropped before ack, then reset during service.
        do_cycle();
        mie_mtie = 1'b1;
        wait_trap("t5_trap", 10);
        mstatus_mie = 1'b0;
        do_cycle();
        check("t5_drop", trap, 1'b0);
        mstatus_mie = 1'b1;
        wait_trap("t5_trap2", 10);
        pulse_ack();
        rst = 1'b1;
        do_cycle();
        rst = 1'b0;
        check("t5_rst_trap", trap, 1'b0);
        check("t5_rst_cause", irq_cause, 32'h0);
        check("t5_rst_mtip", mtip, 1'b0);
        check("t5_rst_meip", meip, 1'b0);
        bus_read(0);
        check("t5_rst_mtime", last_rd, 32'h0);

`ifdef EXT_IRQ_EDGE_EN
        // Single-cycle pulse is held until its trap is acknowledged.
        mie_mtie = 1'b0;
        mie_meie = 1'b0;
        ext_irq = 1'b1;
        do_cycle();
        ext_irq = 1'b0;
        for (int i = 0; i < 8; i++) do_cycle();
        check("t6_sticky", meip, 1'b1);
        mie_meie = 1'b1;
        wait_trap("t6_trap", 4);
        check("t6_cause", irq_cause, EXP_EXT);
        pulse_ack();
        check("t6_cleared", meip, 1'b0);
        pulse_mret();
`endif

        // Randomized run against the model.
        mstatus_mie = 1'b1;
        mie_mtie = 1'b1;
        mie_meie = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            randomize_inputs();
            do_cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
